// File: rtl/sprite_pkg.sv
// Shared types and constants for the palette-indexed sprite ROM.
//   color_t            24-bit RGB colour
//   DEFAULT_PALETTE    power-on / reset palette contents (entries 0..8)
//   DEFAULT_TRANSP_IDX palette index treated as transparent by default
package sprite_pkg;

  typedef logic [23:0] color_t;

  localparam int DEFAULT_TRANSP_IDX = 0;
  localparam int NUM_DEFAULTS       = 9;

  localparam color_t DEFAULT_PALETTE [NUM_DEFAULTS] = '{
    24'hffffff, 24'h000000, 24'hb28558, 24'hdcc3ac, 24'h69441a,
    24'ha0a0a0, 24'h908f8d, 24'h413f39, 24'h303232
  };

  // Entries beyond the listed defaults reset to black.
  function automatic color_t default_color(int idx);
    if (idx < NUM_DEFAULTS) return DEFAULT_PALETTE[idx[3:0]];
    return '0;
  endfunction

endpackage

// File: rtl/palette_regfile.sv
// Run-time writable palette: 2**IDX_W entries of COLOR_W bits.
//   Clk, Reset          clock, synchronous active-high reset (restores defaults)
//   pal_we/pal_idx/pal_data  write port, takes effect on the next edge
//   rd_en/rd_idx        registered read port; rd_data holds while rd_en=0
// A read and a write to the same entry on one edge return the old colour.
module palette_regfile
  import sprite_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_idx,
  input  logic [COLOR_W-1:0] pal_data,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COLOR_W-1:0] rd_data
);

  localparam int ENTRIES = 2**IDX_W;

  logic [ENTRIES-1:0][COLOR_W-1:0] mem;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= COLOR_W'(default_color(i));
      rd_data <= '0;
    end else begin
      if (pal_we) mem[pal_idx] <= pal_data;
      if (rd_en)  rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/palette_sprite_rom.sv
// Palette-indexed sprite/title image ROM with valid/ready request and
// response handshakes. Three stages: S0 bounds check + address, S1 ROM read,
// S2 palette lookup. The whole pipe freezes while a response is held.
//   Clk, Reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; req_x/req_y/req_frame coords
//   rsp_valid/rsp_ready        response handshake
//   rsp_color/rsp_transparent/rsp_oob  response payload
//   pal_we/pal_idx/pal_data    palette write port
// Build option: SPRITE_MIRROR_EN adds req_mirror (horizontal flip of x).
module palette_sprite_rom
  import sprite_pkg::*;
#(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 288,
  parameter int NUM_FRAMES = 1,
  parameter int IDX_W      = 4,
  parameter int COLOR_W    = 24,
  parameter int TRANSP_IDX = DEFAULT_TRANSP_IDX,
  parameter     MIF_FILE   = "sprite_rom.mif",
  parameter int X_W        = $clog2(IMG_W),
  parameter int Y_W        = $clog2(IMG_H),
  parameter int F_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  parameter int ADDR_W     = $clog2(NUM_FRAMES*IMG_W*IMG_H)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  input  logic [F_W-1:0]     req_frame,
`ifdef SPRITE_MIRROR_EN
  input  logic               req_mirror,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [COLOR_W-1:0] rsp_color,
  output logic               rsp_transparent,
  output logic               rsp_oob,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_idx,
  input  logic [COLOR_W-1:0] pal_data
);

  localparam int STAGES = 3;
  localparam int DEPTH  = NUM_FRAMES*IMG_W*IMG_H;

  (* ram_init_file = MIF_FILE *) logic [IDX_W-1:0] rom [0:DEPTH-1];

  logic [STAGES-1:0]  vld_pipe;
  logic               stall, accept;
  logic               oob_c, oob0, oob1, oob2, transp2;
  logic [X_W-1:0]     x_eff;
  logic [ADDR_W-1:0]  addr_c, addr0;
  logic [IDX_W-1:0]   rom_q;
  logic [COLOR_W-1:0] pal_q;

  assign rsp_valid = vld_pipe[STAGES-1];
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;

  // Compare at 32 bits so an input wider than the image range is caught
  // without any prior truncation.
  assign oob_c = (32'(req_x) >= IMG_W) || (32'(req_y) >= IMG_H) ||
                 (32'(req_frame) >= NUM_FRAMES);

`ifdef SPRITE_MIRROR_EN
  assign x_eff = req_mirror ? (X_W'(IMG_W-1) - req_x) : req_x;
`else
  assign x_eff = req_x;
`endif

  assign addr_c = ADDR_W'(req_frame) * ADDR_W'(IMG_W*IMG_H) +
                  ADDR_W'(req_y) * ADDR_W'(IMG_W) + ADDR_W'(x_eff);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe <= '0;
      oob0     <= 1'b0;
      oob1     <= 1'b0;
      oob2     <= 1'b0;
      transp2  <= 1'b0;
      addr0    <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], accept};
      oob0     <= oob_c;
      // OOB requests read a harmless in-range word; the data is discarded.
      addr0    <= oob_c ? '0 : addr_c;
      oob1     <= oob0;
      oob2     <= oob1;
      transp2  <= oob1 || (rom_q == IDX_W'(TRANSP_IDX));
    end
  end

  // Kept free of reset so the array maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (!stall) rom_q <= rom[addr0];
  end

  palette_regfile #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_pal (
    .Clk      (Clk),
    .Reset    (Reset),
    .pal_we   (pal_we),
    .pal_idx  (pal_idx),
    .pal_data (pal_data),
    .rd_en    (!stall),
    .rd_idx   (rom_q),
    .rd_data  (pal_q)
  );

  assign rsp_color       = oob2 ? '0 : pal_q;
  assign rsp_transparent = transp2;
  assign rsp_oob         = oob2;

endmodule
